// File: rtl/picosoc_iomem_timer_pkg.sv
// Shared definitions for the iomem timer/PWM slave: register word indices,
// CTRL/STATUS bit positions and the byte-strobe merge helper.
package picosoc_iomem_timer_pkg;

  // Register word index, i.e. iomem_addr[7:2] inside the 256-byte window.
  typedef logic [5:0] reg_idx_t;

  localparam reg_idx_t REG_CTRL   = 6'h00;  // byte offset 0x00
  localparam reg_idx_t REG_PRESC  = 6'h01;  // byte offset 0x04
  localparam reg_idx_t REG_RELOAD = 6'h02;  // byte offset 0x08
  localparam reg_idx_t REG_COUNT  = 6'h03;  // byte offset 0x0C
  localparam reg_idx_t REG_STATUS = 6'h04;  // byte offset 0x10
  localparam reg_idx_t REG_DUTY0  = 6'h05;  // byte offset 0x14
  localparam reg_idx_t REG_DUTY1  = 6'h06;  // byte offset 0x18

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STATUS_EXP   = 0;

  // Replace the bytes of old_val selected by strb with the matching bytes of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/picosoc_iomem_timer_pwm_chan.sv
// One PWM channel: compares the shared PWM counter with this channel's duty
// value and registers the result, so the LED pin is glitch-free.
module picosoc_iomem_timer_pwm_chan
  import picosoc_iomem_timer_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  logic pwm_q;
  logic pwm_d;

  // High while the counter is below duty: duty 0 never lights, max duty misses one slot.
  always_comb begin
    pwm_d = (cnt_i < duty_i);
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/picosoc_iomem_timer.sv
// Memory-mapped timer/PWM slave on the SoC iomem bus.
// Bus handshake: a request is selected when iomem_valid is high and the
// address falls in this block's 256-byte window; on the first edge that sees
// the selection with iomem_ready low, the access is performed (write applied,
// read data registered) and iomem_ready pulses high for exactly one cycle with
// iomem_rdata valid in that same cycle. rdata is zero whenever ready is low.
module picosoc_iomem_timer
  import picosoc_iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
  parameter int          PRESCALE_BITS = 16,
  parameter int          PWM_BITS      = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out,
  output logic [1:0]  pwm_out
);

  logic                     ready_q, ready_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [2:0]               ctrl_q, ctrl_d;
  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
  logic [31:0]              reload_q, reload_d;
  logic [31:0]              count_q, count_d;
  logic                     exp_q, exp_d;
  logic                     irq_q, irq_d;
  logic [PWM_BITS-1:0]      duty0_q, duty0_d;
  logic [PWM_BITS-1:0]      duty1_q, duty1_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;

  logic        sel, access, wr_en, tick, exp_set;
  logic        ctrl_wr, count_wr, status_w1c;
  reg_idx_t    word_idx;
  logic [31:0] rd_val, wr_val;
  logic        unused_addr_lsb;

  assign sel        = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign access     = sel && !ready_q;
  assign wr_en      = access && (iomem_wstrb != 4'b0000);
  assign word_idx   = iomem_addr[7:2];
  assign tick       = (pcnt_q == presc_q);
  assign ctrl_wr    = wr_en && (word_idx == REG_CTRL);
  assign count_wr   = wr_en && (word_idx == REG_COUNT);
  assign status_w1c = wr_en && (word_idx == REG_STATUS) &&
                      iomem_wstrb[0] && iomem_wdata[STATUS_EXP];
  // Sub-word address bits do not select anything; accesses are word-wide.
  assign unused_addr_lsb = ^iomem_addr[1:0];

  // Current value of the addressed register; unmapped offsets read as zero.
  always_comb begin
    rd_val = 32'h0;
    case (word_idx)
      REG_CTRL:   rd_val[2:0]               = ctrl_q;
      REG_PRESC:  rd_val[PRESCALE_BITS-1:0] = presc_q;
      REG_RELOAD: rd_val                    = reload_q;
      REG_COUNT:  rd_val                    = count_q;
      REG_STATUS: rd_val[STATUS_EXP]        = exp_q;
      REG_DUTY0:  rd_val[PWM_BITS-1:0]      = duty0_q;
      REG_DUTY1:  rd_val[PWM_BITS-1:0]      = duty1_q;
      default:    rd_val                    = 32'h0;
    endcase
  end

  // Byte-strobed write value built on top of the register's current contents.
  always_comb begin
    wr_val = merge_bytes(rd_val, iomem_wdata, iomem_wstrb);
  end

  // Bus acknowledge: one ready pulse per access, data only alongside ready.
  always_comb begin
    ready_d = access;
    rdata_d = access ? rd_val : 32'h0;
  end

  // Prescaler, timer, PWM counter and register updates with their edge priorities.
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    reload_d  = reload_q;
    count_d   = count_q;
    exp_d     = exp_q;
    duty0_d   = duty0_q;
    duty1_d   = duty1_q;
    exp_set   = 1'b0;

    // Free-running prescaler; enabling the timer restarts it so the first tick is a full period away.
    pcnt_d = tick ? '0 : pcnt_q + PRESCALE_BITS'(1);
    if (ctrl_wr && wr_val[CTRL_EN] && !ctrl_q[CTRL_EN]) begin
      pcnt_d = '0;
    end

    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;

    if (tick && ctrl_q[CTRL_EN]) begin
      if (count_q != 32'h0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_set = 1'b1;
        if (ctrl_q[CTRL_ONESHOT]) begin
          ctrl_d[CTRL_EN] = 1'b0;
        end else begin
          count_d = reload_q;
        end
      end
    end

    // Hardware expiry wins over a simultaneous software clear.
    if (status_w1c) exp_d = 1'b0;
    if (exp_set)    exp_d = 1'b1;

    // Software writes win over the hardware updates above.
    if (ctrl_wr)  ctrl_d  = wr_val[2:0];
    if (count_wr) count_d = wr_val;
    if (wr_en && (word_idx == REG_PRESC))  presc_d  = wr_val[PRESCALE_BITS-1:0];
    if (wr_en && (word_idx == REG_RELOAD)) reload_d = wr_val;
    if (wr_en && (word_idx == REG_DUTY0))  duty0_d  = wr_val[PWM_BITS-1:0];
    if (wr_en && (word_idx == REG_DUTY1))  duty1_d  = wr_val[PWM_BITS-1:0];
  end

  // Interrupt follows EXP gated by IRQ_EN, one register stage late.
  always_comb begin
    irq_d = exp_q && ctrl_q[CTRL_IRQ_EN];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      ctrl_q    <= 3'b000;
      presc_q   <= '0;
      pcnt_q    <= '0;
      reload_q  <= 32'h0;
      count_q   <= 32'h0;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
      duty0_q   <= '0;
      duty1_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      irq_q     <= irq_d;
      duty0_q   <= duty0_d;
      duty1_q   <= duty1_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  picosoc_iomem_timer_pwm_chan #(.PWM_BITS(PWM_BITS)) u_pwm0 (
    .clk    (clk),
    .resetn (resetn),
    .cnt_i  (pwm_cnt_q),
    .duty_i (duty0_q),
    .pwm_o  (pwm_out[0])
  );

  picosoc_iomem_timer_pwm_chan #(.PWM_BITS(PWM_BITS)) u_pwm1 (
    .clk    (clk),
    .resetn (resetn),
    .cnt_i  (pwm_cnt_q),
    .duty_i (duty1_q),
    .pwm_o  (pwm_out[1])
  );

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq_out     = irq_q;

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Self-checking bench for picosoc_iomem_timer: directed scenarios plus
// randomized register, timer and PWM checks against an arithmetic model.
module tb_picosoc_iomem_timer;

  localparam logic [31:0] BASE       = 32'h0300_0000;
  localparam logic [7:0]  OFF_CTRL   = 8'h00;
  localparam logic [7:0]  OFF_PRESC  = 8'h04;
  localparam logic [7:0]  OFF_RELOAD = 8'h08;
  localparam logic [7:0]  OFF_COUNT  = 8'h0C;
  localparam logic [7:0]  OFF_STATUS = 8'h10;
  localparam logic [7:0]  OFF_DUTY0  = 8'h14;
  localparam logic [7:0]  OFF_DUTY1  = 8'h18;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        irq_out;
  logic [1:0]  pwm_out;

  int          tests_run = 0;
  int          tests_failed = 0;
  int unsigned cyc = 0;        // number of rising edges so far
  int unsigned last_edge = 0;  // edge at which the last access was performed
  int unsigned last_lat = 0;   // edges from request to ready
  logic        ready_after = 1'b0;

  picosoc_iomem_timer dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq_out     (irq_out),
    .pwm_out     (pwm_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at #1 after a rising edge) ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) step(1);
  endtask

  task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output bit acked);
    acked = 1'b0;
    rdata = 32'h0;
    last_lat = 0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wdata;
    for (int i = 0; i < 4 && !acked; i++) begin
      step(1);
      last_lat++;
      if (iomem_ready) begin
        acked = 1'b1;
        rdata = iomem_rdata;
        last_edge = cyc;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    step(1);
    ready_after = iomem_ready;
  endtask

  task automatic reg_write(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] rd;
    bit ok;
    bus_access(BASE + {24'h0, off}, strb, data, rd, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bus_ack_write off=%0h: got no ready, expected ready", off);
    end
  endtask

  task automatic reg_read(input logic [7:0] off, output logic [31:0] data);
    bit ok;
    bus_access(BASE + {24'h0, off}, 4'h0, 32'h0, data, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bus_ack_read off=%0h: got no ready, expected ready", off);
    end
  endtask

  task automatic wait_irq(input int unsigned limit, output int unsigned at);
    while (!irq_out && cyc < limit) step(1);
    at = irq_out ? cyc : 0;
  endtask

  // ---------------- reference model ----------------
  // COUNT after n ticks from start value c in periodic mode with reload r.
  function automatic logic [31:0] model_count(input int unsigned c, input int unsigned r,
                                              input int unsigned n);
    if (n <= c) return 32'(c - n);
    return 32'(r - ((n - c - 1) % (r + 1)));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    int bad;
    tests_run++;
    if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq_out !== 1'b0 || pwm_out !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b pwm=%b, expected all 0",
               iomem_ready, iomem_rdata, irq_out, pwm_out);
    end
    // Make the block busy, then reset it in the middle of a request.
    reg_write(OFF_PRESC, 4'hF, 32'd0);
    reg_write(OFF_COUNT, 4'hF, 32'd0);
    reg_write(OFF_RELOAD, 4'hF, 32'd7);
    reg_write(OFF_DUTY0, 4'hF, 32'd200);
    reg_write(OFF_DUTY1, 4'hF, 32'd90);
    reg_write(OFF_CTRL, 4'hF, 32'h5);
    step(4);
    tests_run++;
    if (irq_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_irq: got %b expected 1", irq_out);
    end
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h8;
    iomem_wstrb = 4'h0;
    resetn      = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq_out !== 1'b0 || pwm_out !== 2'b00) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_access: got %0d bad cycles, expected 0", bad);
    end
    iomem_valid = 1'b0;
    resetn = 1'b1;
    step(1);
    for (int o = 0; o <= 'h18; o += 4) begin
      reg_read(8'(o), rd);
      tests_run++;
      if (rd !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_reg off=%0h: got %h expected 0", o, rd);
      end
    end
  endtask

  task automatic test_bus();
    logic [31:0] rd;
    bit ok;
    reg_write(OFF_RELOAD, 4'b0011, 32'h1234_5678);
    reg_read(OFF_RELOAD, rd);
    tests_run++;
    if (rd !== 32'h0000_5678) begin
      tests_failed++;
      $display("FAIL bus_wstrb: got %h expected 00005678", rd);
    end
    tests_run++;
    if (last_lat != 1 || ready_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL bus_latency: got lat=%0d ready_after=%b expected lat=1 ready_after=0",
               last_lat, ready_after);
    end
    bus_access(32'h0400_0000, 4'h0, 32'h0, rd, ok);
    tests_run++;
    if (ok) begin
      tests_failed++;
      $display("FAIL bus_out_of_window: got ready expected none");
    end
    bus_access(BASE + 32'h20, 4'hF, 32'hFFFF_FFFF, rd, ok);
    bus_access(BASE + 32'h20, 4'h0, 32'h0, rd, ok);
    tests_run++;
    if (!ok || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL bus_unmapped: got ack=%b rdata=%h expected ack=1 rdata=0", ok, rd);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    int bad_data;
    acks = 0;
    bad_data = 0;
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h8;
    iomem_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (iomem_ready) begin
        acks++;
        if (iomem_rdata !== 32'h0000_5678) bad_data++;
      end
    end
    iomem_valid = 1'b0;
    step(1);
    tests_run++;
    if (acks != 3 || bad_data != 0) begin
      tests_failed++;
      $display("FAIL back_to_back: got acks=%0d bad_data=%0d expected acks=3 bad_data=0", acks, bad_data);
    end
  endtask

  task automatic test_random_regs();
    logic [31:0] model [7];
    logic [31:0] mask  [7];
    logic [31:0] rd, wd, m;
    logic [3:0]  strb;
    int idx;
    for (int i = 0; i < 7; i++) mask[i] = 32'h0;
    mask[1] = 32'h0000_FFFF;
    mask[2] = 32'hFFFF_FFFF;
    mask[3] = 32'hFFFF_FFFF;
    mask[5] = 32'h0000_00FF;
    mask[6] = 32'h0000_00FF;
    for (int i = 0; i < 7; i++) begin
      reg_read(8'(i * 4), rd);
      model[i] = rd & mask[i];
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: idx = 1;
        1: idx = 2;
        2: idx = 3;
        3: idx = 5;
        default: idx = 6;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        wd   = $urandom;
        strb = 4'($urandom_range(1, 15));
        reg_write(8'(idx * 4), strb, wd);
        m = model[idx];
        for (int b = 0; b < 4; b++) if (strb[b]) m[b*8 +: 8] = wd[b*8 +: 8];
        model[idx] = m & mask[idx];
      end else begin
        reg_read(8'(idx * 4), rd);
        tests_run++;
        if (rd !== model[idx]) begin
          tests_failed++;
          $display("FAIL rand_reg off=%0h: got %h expected %h", idx * 4, rd, model[idx]);
        end
      end
    end
    reg_read(8'(4 * $urandom_range(8, 63)), rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL rand_unmapped: got %h expected 0", rd);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    int unsigned e0, at, w;
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_STATUS, 4'hF, 32'h1);
    reg_write(OFF_PRESC, 4'hF, 32'd3);
    reg_write(OFF_RELOAD, 4'hF, 32'd2);
    reg_write(OFF_COUNT, 4'hF, 32'd2);
    reg_write(OFF_CTRL, 4'hF, 32'h5);
    e0 = last_edge;
    wait_irq(e0 + 40, at);
    tests_run++;
    if (at != e0 + 13) begin
      tests_failed++;
      $display("FAIL periodic_first_irq: got edge %0d expected %0d", at - e0, 13);
    end
    reg_read(OFF_STATUS, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++;
      $display("FAIL periodic_status: got %h expected 1", rd);
    end
    reg_write(OFF_STATUS, 4'h1, 32'h1);
    w = last_edge;
    tests_run++;
    if (irq_out !== 1'b0 || cyc != w + 1) begin
      tests_failed++;
      $display("FAIL periodic_irq_clear: got irq=%b expected 0", irq_out);
    end
    wait_irq(e0 + 60, at);
    tests_run++;
    if (at != e0 + 25) begin
      tests_failed++;
      $display("FAIL periodic_second_irq: got edge %0d expected %0d", at - e0, 25);
    end
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_STATUS, 4'hF, 32'h1);
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    int unsigned e0, at;
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_STATUS, 4'hF, 32'h1);
    reg_write(OFF_PRESC, 4'hF, 32'd0);
    reg_write(OFF_COUNT, 4'hF, 32'd1);
    reg_write(OFF_CTRL, 4'hF, 32'h7);
    e0 = last_edge;
    wait_irq(e0 + 20, at);
    tests_run++;
    if (at != e0 + 3) begin
      tests_failed++;
      $display("FAIL oneshot_irq: got edge %0d expected 3", at - e0);
    end
    reg_read(OFF_CTRL, rd);
    tests_run++;
    if (rd !== 32'h6) begin
      tests_failed++;
      $display("FAIL oneshot_ctrl: got %h expected 6", rd);
    end
    reg_read(OFF_COUNT, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL oneshot_count: got %h expected 0", rd);
    end
    reg_write(OFF_STATUS, 4'hF, 32'h1);
    step(20);
    reg_read(OFF_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0 || irq_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL oneshot_no_rearm: got status=%h irq=%b expected 0 0", rd, irq_out);
    end
    reg_write(OFF_CTRL, 4'hF, 32'h0);
  endtask

  task automatic test_collisions();
    logic [31:0] rd;
    int unsigned e0;
    // W1C landing on the expiry edge: the expiry must survive.
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_STATUS, 4'hF, 32'h1);
    reg_write(OFF_PRESC, 4'hF, 32'd0);
    reg_write(OFF_RELOAD, 4'hF, 32'd5);
    reg_write(OFF_COUNT, 4'hF, 32'd1);
    reg_write(OFF_CTRL, 4'hF, 32'h1);
    e0 = last_edge;
    reg_write(OFF_STATUS, 4'hF, 32'h1);
    tests_run++;
    if (last_edge != e0 + 2) begin
      tests_failed++;
      $display("FAIL w1c_edge: got edge %0d expected 2", last_edge - e0);
    end
    reg_read(OFF_STATUS, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++;
      $display("FAIL w1c_vs_expiry: got %h expected 1", rd);
    end
    // CTRL write landing on the one-shot expiry edge: software value wins.
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_COUNT, 4'hF, 32'd1);
    reg_write(OFF_CTRL, 4'hF, 32'h3);
    reg_write(OFF_CTRL, 4'hF, 32'h1);
    reg_read(OFF_CTRL, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++;
      $display("FAIL ctrl_vs_oneshot: got %h expected 1", rd);
    end
    // COUNT write landing on a tick edge: written value wins.
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_PRESC, 4'hF, 32'd9);
    reg_write(OFF_COUNT, 4'hF, 32'd50);
    reg_write(OFF_CTRL, 4'hF, 32'h1);
    e0 = last_edge;
    wait_until(e0 + 9);
    reg_write(OFF_COUNT, 4'hF, 32'd100);
    tests_run++;
    if (last_edge != e0 + 10) begin
      tests_failed++;
      $display("FAIL count_wr_edge: got edge %0d expected 10", last_edge - e0);
    end
    reg_read(OFF_COUNT, rd);
    tests_run++;
    if (rd !== 32'd100) begin
      tests_failed++;
      $display("FAIL count_wr_vs_tick: got %0d expected 100", rd);
    end
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_STATUS, 4'hF, 32'h1);
  endtask

  task automatic test_random_count();
    logic [31:0] rd, exp_v;
    int unsigned p, c, r, e0, n;
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(0, 3);
      c = $urandom_range(0, 5);
      r = $urandom_range(0, 4);
      reg_write(OFF_CTRL, 4'hF, 32'h0);
      reg_write(OFF_PRESC, 4'hF, p);
      reg_write(OFF_RELOAD, 4'hF, r);
      reg_write(OFF_COUNT, 4'hF, c);
      reg_write(OFF_CTRL, 4'hF, 32'h1);
      e0 = last_edge;
      step($urandom_range(0, 40));
      reg_read(OFF_COUNT, rd);
      n = (last_edge - e0 - 1) / (p + 1);
      exp_v = model_count(c, r, n);
      tests_run++;
      if (rd !== exp_v) begin
        tests_failed++;
        $display("FAIL rand_count p=%0d c=%0d r=%0d ticks=%0d: got %0d expected %0d", p, c, r, n, rd, exp_v);
      end
    end
    reg_write(OFF_CTRL, 4'hF, 32'h0);
  endtask

  task automatic test_random_irq();
    int unsigned p, c, e0, at, exp_at;
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(0, 3);
      c = $urandom_range(0, 5);
      reg_write(OFF_CTRL, 4'hF, 32'h0);
      reg_write(OFF_STATUS, 4'hF, 32'h1);
      reg_write(OFF_PRESC, 4'hF, p);
      reg_write(OFF_RELOAD, 4'hF, 32'd3);
      reg_write(OFF_COUNT, 4'hF, c);
      reg_write(OFF_CTRL, 4'hF, 32'h5);
      e0 = last_edge;
      exp_at = e0 + (c + 1) * (p + 1) + 1;
      wait_irq(exp_at + 10, at);
      tests_run++;
      if (at != exp_at) begin
        tests_failed++;
        $display("FAIL rand_irq p=%0d c=%0d: got edge %0d expected %0d", p, c, at - e0, exp_at - e0);
      end
    end
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_STATUS, 4'hF, 32'h1);
  endtask

  task automatic pwm_measure(input int unsigned p, input int unsigned d0, input int unsigned d1,
                             input string name);
    int h0, h1;
    int unsigned win;
    reg_write(OFF_CTRL, 4'hF, 32'h0);
    reg_write(OFF_PRESC, 4'hF, p);
    reg_write(OFF_DUTY0, 4'hF, d0);
    reg_write(OFF_DUTY1, 4'hF, d1);
    reg_write(OFF_CTRL, 4'hF, 32'h1);
    step(4);
    win = 256 * (p + 1);
    h0 = 0;
    h1 = 0;
    for (int unsigned i = 0; i < win; i++) begin
      step(1);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
    end
    tests_run++;
    if (h0 != int'(d0 * (p + 1)) || h1 != int'(d1 * (p + 1))) begin
      tests_failed++;
      $display("FAIL %s p=%0d: got high0=%0d high1=%0d expected %0d %0d",
               name, p, h0, h1, d0 * (p + 1), d1 * (p + 1));
    end
  endtask

  task automatic test_pwm();
    pwm_measure(0, 64, 0, "pwm_64_0");
    pwm_measure(0, 255, 1, "pwm_255_1");
    for (int it = 0; it < 3; it++) begin
      pwm_measure($urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 255), "pwm_rand");
    end
    reg_write(OFF_CTRL, 4'hF, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetn = 1'b0;
    step(3);
    resetn = 1'b1;
    step(1);
    test_reset();
    test_bus();
    test_back_to_back();
    test_random_regs();
    test_periodic();
    test_oneshot();
    test_collisions();
    test_random_count();
    test_random_irq();
    test_pwm();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
